// File: rtl/kpn_sub_arbiter_if.sv
// kpn_sub_arbiter_if
// Bundles the channel-side signals of the shared subtract arbiter. Every
// per-channel vector is packed with channel c at [c*WIDTH +: WIDTH] for data
// and at bit c for flags and strobes.
//
//   a_data/b_data  token heads of the A/B input FIFOs (registered-read)
//   a_empty/b_empty input FIFO empty flags
//   a_rd/b_rd      input FIFO pop strobes (one-cycle pulses)
//   out_data       per-channel result register
//   out_full       output FIFO full flags
//   out_wr         output FIFO push strobes (one-cycle pulses)
//   grant          one-hot owner of the datapath, 0 when idle
//   op_count       completed transactions, both channels, wrapping
//
// slave  : the arbiter's view
// master : the FIFO / environment view
interface kpn_sub_arbiter_if #(
  parameter int WIDTH = 16
);
  logic [2*WIDTH-1:0] a_data;
  logic [1:0]         a_empty;
  logic [1:0]         a_rd;
  logic [2*WIDTH-1:0] b_data;
  logic [1:0]         b_empty;
  logic [1:0]         b_rd;
  logic [2*WIDTH-1:0] out_data;
  logic [1:0]         out_full;
  logic [1:0]         out_wr;
  logic [1:0]         grant;
  logic [15:0]        op_count;

  modport slave (
    input  a_data, a_empty, b_data, b_empty, out_full,
    output a_rd, b_rd, out_data, out_wr, grant, op_count
  );

  modport master (
    output a_data, a_empty, b_data, b_empty, out_full,
    input  a_rd, b_rd, out_data, out_wr, grant, op_count
  );
endinterface

// File: rtl/kpn_sub_arbiter.sv
// kpn_sub_arbiter
// One saturating subtractor shared round-robin between two KPN channels. A
// granted transaction pops one token from the channel's A and B FIFOs,
// computes max(A-B, 0) and pushes it into that channel's output FIFO.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    kpn_sub_arbiter_if.slave (FIFO flags/data in, strobes/results out)
//
// state | meaning
// IDLE  | sample eligibility, pick a channel, launch pop strobes
// READ  | a_rd/b_rd of the granted channel high this cycle
// EXEC  | FIFO heads valid, capture clamped difference into out_data[g]
// WRITE | wait for out_full[g]==0, then pulse out_wr[g] and return to IDLE
//
// All outputs come straight from flops. The pop strobes are loaded together
// with the grant, so they are high exactly during READ. The push strobe is
// loaded when WRITE sees room, so it is high during the IDLE cycle that
// follows; grant to out_wr is therefore three cycles and one result can
// complete every four cycles. The downstream FIFO only fills through our own
// writes, so the one-cycle gap between sampling out_full and pushing is safe.
module kpn_sub_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  kpn_sub_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  state_t             state;
  logic               last;       // index of the most recently granted channel
  logic [1:0]         grant_q;
  logic [1:0]         a_rd_q;
  logic [1:0]         b_rd_q;
  logic [1:0]         out_wr_q;
  logic [2*WIDTH-1:0] out_data_q;
  logic [15:0]        op_cnt;

  logic [1:0]         elig;
  logic               pick;
  logic [1:0]         pick_oh;
  logic [WIDTH-1:0]   a_sel;
  logic [WIDTH-1:0]   b_sel;
  logic [WIDTH-1:0]   diff;

  assign elig = ~bus.a_empty & ~bus.b_empty & ~bus.out_full;

  // With both eligible the channel not served last wins; otherwise the
  // single eligible one.
  assign pick    = (elig == 2'b11) ? ~last : elig[1];
  assign pick_oh = pick ? 2'b10 : 2'b01;

  // Outside IDLE, last is the granted channel.
  assign a_sel = last ? bus.a_data[2*WIDTH-1:WIDTH] : bus.a_data[WIDTH-1:0];
  assign b_sel = last ? bus.b_data[2*WIDTH-1:WIDTH] : bus.b_data[WIDTH-1:0];
  assign diff  = (a_sel > b_sel) ? (a_sel - b_sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last       <= 1'b1;
      grant_q    <= '0;
      a_rd_q     <= '0;
      b_rd_q     <= '0;
      out_wr_q   <= '0;
      out_data_q <= '0;
      op_cnt     <= '0;
    end else begin
      a_rd_q   <= '0;
      b_rd_q   <= '0;
      out_wr_q <= '0;
      case (state)
        IDLE: begin
          if (elig != 2'b00) begin
            grant_q <= pick_oh;
            last    <= pick;
            a_rd_q  <= pick_oh;
            b_rd_q  <= pick_oh;
            state   <= READ;
          end
        end
        READ: begin
          state <= EXEC;
        end
        EXEC: begin
          if (last) out_data_q[2*WIDTH-1:WIDTH] <= diff;
          else      out_data_q[WIDTH-1:0]       <= diff;
          state <= WRITE;
        end
        WRITE: begin
          if (!bus.out_full[last]) begin
            out_wr_q <= grant_q;
            op_cnt   <= op_cnt + 16'd1;
            grant_q  <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_rd     = a_rd_q;
  assign bus.b_rd     = b_rd_q;
  assign bus.out_wr   = out_wr_q;
  assign bus.out_data = out_data_q;
  assign bus.grant    = grant_q;
  assign bus.op_count = op_cnt;

endmodule

// File: tb/tb_kpn_sub_arbiter.sv
// Directed bench for kpn_sub_arbiter. Token FIFOs are modelled with queues;
// every pushed token pair also pushes the expected clamped difference into a
// per-channel scoreboard that is popped on each out_wr.
module tb_kpn_sub_arbiter;
  localparam int W = 16;

  logic clk;
  logic rst_n;

  kpn_sub_arbiter_if #(.WIDTH(W)) bus();

  kpn_sub_arbiter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [2*W-1:0] a_dat, b_dat;
  logic [1:0]     a_emp, b_emp, full_force, blk_a, blk_b;

  assign bus.a_data   = a_dat;
  assign bus.b_data   = b_dat;
  assign bus.a_empty  = a_emp;
  assign bus.b_empty  = b_emp;
  assign bus.out_full = full_force;

  logic [W-1:0] aq[2][$];
  logic [W-1:0] bq[2][$];
  logic [W-1:0] expq[2][$];
  logic [W-1:0] last_wr[2];
  int           wr_cnt[2];
  logic [1:0]   glog[$];
  logic [1:0]   prev_grant;
  int           cyc;
  int           n_tests, n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic update_flags();
    for (int c = 0; c < 2; c++) begin
      a_emp[c] = (aq[c].size() == 0) || blk_a[c];
      b_emp[c] = (bq[c].size() == 0) || blk_b[c];
    end
  endtask

  task automatic push_pair(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
    aq[c].push_back(a);
    bq[c].push_back(b);
    expq[c].push_back((a > b) ? a - b : '0);
    update_flags();
  endtask

  // One cycle: advance to the falling edge, then act as FIFOs and monitor.
  task automatic tick();
    logic [W-1:0] exp_v;
    @(negedge clk);
    cyc++;
    if ((bus.a_rd | bus.b_rd) != 2'b00)
      chk("rd_pair", {bus.a_rd, bus.b_rd}, {bus.grant, bus.grant});
    for (int c = 0; c < 2; c++) begin
      if (bus.a_rd[c]) begin
        chk("rd_nonempty", (aq[c].size() != 0) && (bq[c].size() != 0), 1);
        if (aq[c].size() != 0) a_dat[c*W +: W] = aq[c].pop_front();
      end
      if (bus.b_rd[c] && bq[c].size() != 0) b_dat[c*W +: W] = bq[c].pop_front();
    end
    for (int c = 0; c < 2; c++) begin
      if (bus.out_wr[c]) begin
        chk("wr_expected", expq[c].size() > 0, 1);
        if (expq[c].size() > 0) begin
          exp_v = expq[c].pop_front();
          chk($sformatf("wr_data_ch%0d", c), bus.out_data[c*W +: W], exp_v);
        end
        chk($sformatf("idle_hold_ch%0d", 1 - c), bus.out_data[(1-c)*W +: W], last_wr[1-c]);
        last_wr[c] = bus.out_data[c*W +: W];
        wr_cnt[c]++;
      end
    end
    if (bus.grant != 2'b00 && bus.grant != prev_grant) glog.push_back(bus.grant);
    prev_grant = bus.grant;
    update_flags();
  endtask

  task automatic wait_grant(input int budget, output int gc);
    int n = 0;
    while (bus.grant == 2'b00 && n < budget) begin
      tick();
      n++;
    end
    gc = cyc;
    chk("grant_seen", bus.grant != 2'b00, 1);
  endtask

  task automatic wait_wr(input int c, input int budget);
    int n = 0;
    while (!bus.out_wr[c] && n < budget) begin
      tick();
      n++;
    end
    chk("wr_seen", bus.out_wr[c], 1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((expq[0].size() + expq[1].size() != 0 || bus.grant != 0 || bus.out_wr != 0)
           && n < budget) begin
      tick();
      n++;
    end
    chk("drain", expq[0].size() + expq[1].size(), 0);
  endtask

  initial begin
    int g;
    int w0, w1;
    n_tests = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b0;
    a_dat = '0; b_dat = '0;
    blk_a = '0; blk_b = '0; full_force = '0;
    prev_grant = '0;
    last_wr[0] = '0; last_wr[1] = '0;
    wr_cnt[0] = 0; wr_cnt[1] = 0;
    update_flags();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_a_rd", bus.a_rd, 0);
    chk("rst_b_rd", bus.b_rd, 0);
    chk("rst_out_wr", bus.out_wr, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_op_count", bus.op_count, 0);
    rst_n = 1'b1;
    tick();

    // Single op on channel 0
    push_pair(0, 16'h0010, 16'h0003);
    wait_grant(20, g);
    chk("t1_grant", bus.grant, 2'b01);
    chk("t1_rd", {bus.a_rd, bus.b_rd}, 4'b0101);
    tick();
    chk("t1_rd_drop", {bus.a_rd, bus.b_rd}, 0);
    wait_wr(0, 20);
    chk("t1_latency", cyc - g, 3);
    chk("t1_data", bus.out_data[W-1:0], 16'h000D);
    chk("t1_op_count", bus.op_count, 1);
    wait_drain(20);

    // Clamp cases on channel 1
    push_pair(1, 16'h0005, 16'h0005);
    push_pair(1, 16'h0003, 16'h0009);
    push_pair(1, 16'hFFFF, 16'h0001);
    wait_drain(60);
    chk("t2_last", bus.out_data[2*W-1:W], 16'hFFFE);
    chk("t2_ch0_kept", bus.out_data[W-1:0], 16'h000D);
    chk("t2_op_count", bus.op_count, 4);

    // Both channels eligible: strict alternation starting with channel 0
    glog.delete();
    w0 = wr_cnt[0]; w1 = wr_cnt[1];
    for (int i = 0; i < 4; i++) begin
      push_pair(0, 16'h1000 + 16'(i) * 16'h0111, 16'h0100 * 16'(i));
      push_pair(1, 16'h0050 * 16'(i), 16'h0020 + 16'(i));
    end
    wait_drain(100);
    chk("t3_grants", glog.size(), 8);
    for (int i = 0; i < 8 && i < glog.size(); i++)
      chk($sformatf("t3_grant_%0d", i), glog[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    chk("t3_wr_ch0", wr_cnt[0] - w0, 4);
    chk("t3_wr_ch1", wr_cnt[1] - w1, 4);

    // Backpressure in WRITE
    push_pair(0, 16'h1234, 16'h0234);
    wait_grant(20, g);
    full_force[0] = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_stall", {bus.out_wr, bus.grant}, 4'b0001);
      chk("t4_res", bus.out_data[W-1:0], 16'h1000);
    end
    full_force[0] = 1'b0;
    tick();
    chk("t4_release_wr", bus.out_wr, 2'b01);
    wait_drain(20);

    // Empty gating
    blk_b[0] = 1'b1;
    push_pair(0, 16'h0042, 16'h0002);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_hold", {bus.grant, bus.a_rd, bus.b_rd}, 0);
    end
    blk_b[0] = 1'b0;
    update_flags();
    wait_drain(30);
    chk("t5_data", bus.out_data[W-1:0], 16'h0040);

    // Reset during EXEC, then op_count wrap
    push_pair(0, 16'h0007, 16'h0002);
    wait_grant(20, g);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ctl", {bus.grant, bus.a_rd, bus.b_rd, bus.out_wr}, 0);
    chk("t6_rst_data", bus.out_data, 0);
    chk("t6_rst_count", bus.op_count, 0);
    expq[0].delete();
    last_wr[0] = '0; last_wr[1] = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_no_wr", bus.out_wr, 0);
    end
    rst_n = 1'b1;
    tick();
    force dut.op_cnt = 16'hFFFF;
    tick();
    release dut.op_cnt;
    tick();
    chk("t6_preload", bus.op_count, 16'hFFFF);
    glog.delete();
    push_pair(0, 16'h0009, 16'h0004);
    push_pair(1, 16'h0008, 16'h0001);
    wait_wr(0, 20);
    chk("t6_wrap", bus.op_count, 16'h0000);
    wait_drain(30);
    chk("t6_first_grant", (glog.size() > 0) ? glog[0] : 2'b00, 2'b01);
    chk("t6_op_count", bus.op_count, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
